bram_fill_ctrl: RTL
===================

Name: bram_fill_ctrl

Overview:
- Upstream producer stage for the ping-pong BRAM buffer.
- Accepts a valid/ready word stream (from the DMA/AXI read path), splits a transfer of total_words into segments of at most DEPTH words, and drives the buffer fill interface (seg_words, fill_req, fill_we/addr/wdata).
- Waits for fill_done after each segment before requesting the next one.

Parameters:
- DATA_W, AXI_DATA_WIDTH (32): data word width.
- DEPTH, 64: words per buffer bank; maximum segment length.
- ADDR_W, $clog2(DEPTH): fill address width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- start  in  1  pulse; begin transfer, sampled only in S_IDLE
- total_words  in  32  words in transfer, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at transfer end
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid&&s_ready
- s_data  in  DATA_W  stream word
- seg_words  out  32  current segment length, to buffer
- fill_req  out  1  request a bank for the next segment
- fill_busy  in  1  buffer is filling a bank (registered in buffer)
- fill_we  out  1  write strobe
- fill_addr  out  ADDR_W  word address in bank
- fill_wdata  out  DATA_W  write data
- fill_done  in  1  buffer pulse: segment written

Behaviour:
- Reset (rstn low at posedge): state S_IDLE; all outputs 0; remaining, seg_cnt, seg_words cleared. Reset mid-transfer aborts immediately. No partial-segment recovery; the buffer shares rstn.
- States: S_IDLE, S_REQ, S_STREAM, S_WAIT_DONE, S_FIN.
- S_IDLE, start=1:
  - total_words==0: go to S_FIN; no fill_req is issued.
  - Otherwise: remaining<=total_words; busy<=1; go to S_REQ.
  - start while busy is ignored.
- Entry to S_REQ:
  - seg_words<=min(remaining, DEPTH). A full segment sends DEPTH, never 0.
  - seg_words is held until the next S_REQ entry.
  - seg_cnt<=0.
- S_REQ: fill_req (registered) is high every cycle. When fill_busy==1 is sampled, fill_req<=0 and go to S_STREAM. If no bank is empty, fill_req stays high indefinitely; this is legal.
- S_STREAM:
  - s_ready=1 while seg_cnt<seg_words. It is combinational from state/counter and low after the last word is accepted.
  - On handshake, the next cycle drives fill_we=1, fill_addr=seg_cnt[ADDR_W-1:0], fill_wdata=s_data. Write path latency is 1 cycle.
  - seg_cnt++ and remaining-- on each handshake.
  - After the seg_words-th handshake, go to S_WAIT_DONE. The last registered write issues in the first S_WAIT_DONE cycle.
- S_WAIT_DONE: s_ready=0. On fill_done: remaining>0 goes to S_REQ; otherwise goes to S_FIN.
- S_FIN: done=1 for one cycle; busy<=0; go to S_IDLE.
- fill_we is never asserted outside a granted segment. Gaps in s_valid simply stall. No words are dropped or duplicated.
- Address wraps only at segment start (seg_cnt resets to 0). seg_cnt is 32-bit, so DEPTH words are representable.
- fill_done arriving outside S_WAIT_DONE is ignored. The buffer guarantees this cannot occur.

Optional Feature:
- Macro: BRAM_FILL_LAST_CHK_EN.
- When defined:
  - Adds input s_last (1) and output err_last (1, sticky, cleared on accepted start or reset).
  - err_last<=1 if s_last accompanies a handshake other than the transfer's final word, or if the final word arrives without s_last.
  - Data flow is unchanged.
- When undefined: no s_last or err_last ports, and no check logic.

Decomposition:
- Add fill_state_e (S_IDLE..S_FIN, logic [2:0]) to sa_params_pkg. DATA_W default comes from AXI_DATA_WIDTH there.
- No sub-module. min() is a local function.

Test Plan:
- total_words=130, DEPTH=64, s_valid always 1, fill_done 2 cycles after the last write -> seg_words 64, 64, 2; three fill_req grants; fill_addr 0..63, 0..63, 0..1; done pulses once; 130 fill_we total.
- total_words=0 -> done pulses 2 cycles after start; fill_req, fill_we and s_ready stay 0.
- Buffer holds fill_busy=0 for 20 cycles -> fill_req held high 20+ cycles; s_ready=0 throughout; stream resumes at addr 0 after grant.
- total_words=10, s_valid toggling 1010... -> exactly 10 fill_we, data order preserved, fill_addr 0..9.
- rstn low for 1 cycle mid-segment (word 30 of 64) -> next cycle all outputs 0, state S_IDLE; a new start=64 streams from addr 0.
- BRAM_FILL_LAST_CHK_EN, total_words=8, s_last on word 5 -> err_last=1 the cycle after word 5 and stays 1; next start clears it.

Source files
------------

// File: rtl/sa_params_pkg.sv
// Shared parameters and state encoding for the ping-pong BRAM buffer datapath.
package sa_params_pkg;

  localparam int AXI_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_STREAM    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FIN       = 3'd4
  } fill_state_e;

endpackage

// File: rtl/bram_fill_ctrl.sv
// Producer for the ping-pong BRAM buffer: chops a word stream into bank-sized segments.
// Optional s_last/err_last framing check is enabled by defining BRAM_FILL_LAST_CHK_EN.
module bram_fill_ctrl
  import sa_params_pkg::*;
#(
  parameter int DATA_W = AXI_DATA_WIDTH,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [31:0]       total_words,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [31:0]       seg_words,
  output logic              fill_req,
  input  logic              fill_busy,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_wdata,
  input  logic              fill_done
`ifdef BRAM_FILL_LAST_CHK_EN
  ,
  input  logic              s_last,
  output logic              err_last
`endif
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  function automatic logic [31:0] seg_len(input logic [31:0] words);
    return (words > DEPTH_W) ? DEPTH_W : words;
  endfunction

  fill_state_e       state_q, state_d;
  logic [31:0]       remaining_q, remaining_d;
  logic [31:0]       seg_cnt_q, seg_cnt_d;
  logic [31:0]       seg_words_q, seg_words_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fill_req_q, fill_req_d;
  logic              fill_we_q, fill_we_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_wdata_q, fill_wdata_d;
  logic              handshake;
`ifdef BRAM_FILL_LAST_CHK_EN
  logic              err_last_q, err_last_d;
`endif

  assign s_ready   = (state_q == S_STREAM) && (seg_cnt_q < seg_words_q);
  assign handshake = s_valid && s_ready;

  // NOTE: every _d gets a default before the case so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    seg_cnt_d    = seg_cnt_q;
    seg_words_d  = seg_words_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fill_req_d   = fill_req_q;
    fill_we_d    = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_wdata_d = fill_wdata_q;
`ifdef BRAM_FILL_LAST_CHK_EN
    err_last_d   = err_last_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef BRAM_FILL_LAST_CHK_EN
          err_last_d = 1'b0;
`endif
          if (total_words == 32'd0) begin
            state_d = S_FIN;
          end else begin
            remaining_d = total_words;
            busy_d      = 1'b1;
            seg_words_d = seg_len(total_words);
            seg_cnt_d   = 32'd0;
            fill_req_d  = 1'b1;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (fill_busy) begin
          fill_req_d = 1'b0;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        if (handshake) begin
          fill_we_d    = 1'b1;
          fill_addr_d  = seg_cnt_q[ADDR_W-1:0];
          fill_wdata_d = s_data;
          seg_cnt_d    = seg_cnt_q + 32'd1;
          remaining_d  = remaining_q - 32'd1;
`ifdef BRAM_FILL_LAST_CHK_EN
          // s_last must mark exactly the final word of the whole transfer.
          if (s_last != (remaining_q == 32'd1)) err_last_d = 1'b1;
`endif
          if (seg_cnt_q + 32'd1 == seg_words_q) state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (fill_done) begin
          if (remaining_q != 32'd0) begin
            seg_words_d = seg_len(remaining_q);
            seg_cnt_d   = 32'd0;
            fill_req_d  = 1'b1;
            state_d     = S_REQ;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      seg_cnt_q    <= '0;
      seg_words_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fill_req_q   <= 1'b0;
      fill_we_q    <= 1'b0;
      fill_addr_q  <= '0;
      fill_wdata_q <= '0;
`ifdef BRAM_FILL_LAST_CHK_EN
      err_last_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      seg_cnt_q    <= seg_cnt_d;
      seg_words_q  <= seg_words_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fill_req_q   <= fill_req_d;
      fill_we_q    <= fill_we_d;
      fill_addr_q  <= fill_addr_d;
      fill_wdata_q <= fill_wdata_d;
`ifdef BRAM_FILL_LAST_CHK_EN
      err_last_q   <= err_last_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign seg_words  = seg_words_q;
  assign fill_req   = fill_req_q;
  assign fill_we    = fill_we_q;
  assign fill_addr  = fill_addr_q;
  assign fill_wdata = fill_wdata_q;
`ifdef BRAM_FILL_LAST_CHK_EN
  assign err_last   = err_last_q;
`endif

endmodule
